mem_port_arb: RTL and testbench
===============================

# mem_port_arb

Two-requester arbiter that shares one port of the single-cycle dual-port data/program memory (14-bit word address, 32-bit data, 4-bit byte enables, 1-bit write enable) between two masters, e.g. core data bus and debug/loader. It issues at most one memory access per cycle, routes the read data back to the issuing requester, and supports short locked bursts with a bounded lock length so that neither master can starve the other.

## Interface
Parameters:
- MAX_LOCK, 8: max consecutive grants to one locked requester before forced release (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_i[n] (n=0,1)  in  1  access request; held with all request fields until granted.
- lock_i[n]  in  1  request the next access be granted to the same master.
- we_i[n]  in  1  1=write, 0=read.
- be_i[n]  in  4  byte enables; all-zero is illegal.
- addr_i[n]  in  14  word address.
- wdata_i[n]  in  32  write data.
- gnt_o[n]  out  1  request accepted this cycle (combinational).
- rvalid_o[n]  out  1  response for last granted access (registered).
- rdata_o[n]  out  32  read data; valid with rvalid_o and we=0.
- mem_en_o  out  4  memory byte enables (0 = idle).
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  14  memory address.
- mem_din_o  out  32  memory write data.
- mem_dout_i  in  32  memory read data, valid one cycle after en with we=0.

## Operation
- State: last_owner (1 bit), locked (1 bit), lock_cnt (8 bits), resp_owner/resp_pending/resp_we regs.
- UNLOCKED: single request wins; both requesting -> master != last_owner wins (round-robin).
- Winner W: gnt_o[W]=1; mem_en_o=be_i[W], mem_we_o=we_i[W], addr/din from W. No winner: mem_en_o=0, mem_we_o=0, addr/din=0.
- On grant: last_owner<=W. If lock_i[W]=1 -> LOCKED, lock_cnt<=1; else stay UNLOCKED.
- LOCKED(owner L): only L may be granted; other master waits. On each grant to L: lock_cnt++ ; if lock_i[L]=0 or lock_cnt reaches MAX_LOCK -> UNLOCKED.
- LOCKED and req_i[L]=0 for a cycle -> UNLOCKED immediately (no idle lock holding); the other master may be granted that same cycle.
- Response: cycle after any grant, rvalid_o[W]=1 for exactly one cycle (reads and writes). rdata_o[W]=mem_dout_i for reads, 0 for writes; rdata_o of non-responding master is 0.
- Read data already masked by memory per byte enable; arbiter does not re-mask.

## Timing
- Grant latency: 0 cycles (gnt combinational from req and state). Response latency: 1 cycle.
- Throughput: one access per cycle; back-to-back grants to same or alternating masters legal.
- Both masters requesting continuously, no lock: grants strictly alternate.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, mem_en_o=0, mem_we_o=0, last_owner=1 (master 0 wins first tie), locked=0, lock_cnt=0.
- Reset asserted mid-access: response for in-flight grant dropped (rvalid_o stays 0); state returns to reset values.
- Requester deasserting req without gnt: legal, no effect.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: ties always go to master 0; last_owner ignored for arbitration; lock logic unchanged.
- Undefined (default): round-robin as above.

## Test plan
- Single read: master 0 req, addr=0x0010, be=0xF, mem holds 0xDEADBEEF -> gnt_o[0] same cycle, next cycle rvalid_o[0]=1, rdata_o[0]=0xDEADBEEF.
- Contention: both request reads continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; each rvalid on matching port one cycle later.
- Byte write: master 1 writes 0x11223344 be=0x3 addr=0x0100, then reads be=0xF -> mem_en_o=0x3 on write; readback low half 0x3344 with memory's masking.
- Lock bound: MAX_LOCK=4, master 0 holds lock_i=1, master 1 requesting -> four consecutive grants to 0, then grant to 1.
- Lock drop: master 0 locked, deasserts req for one cycle while master 1 requests -> master 1 granted that cycle.
- Reset mid-read: rstn low in cycle after grant -> rvalid_o stays 0; after release, first tie goes to master 0.

Source files
------------

// File: rtl/mem_port_arb.sv
// Two-master arbiter for one memory port with round-robin ties and bounded locked bursts.
// Define MEM_ARB_FIXED_PRIO_EN to make master 0 win every tie.
module mem_port_arb #(
    parameter int MAX_LOCK = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req_i,
    input  logic [1:0]       lock_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][3:0]  be_i,
    input  logic [1:0][13:0] addr_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [1:0][31:0] rdata_o,
    output logic [3:0]       mem_en_o,
    output logic             mem_we_o,
    output logic [13:0]      mem_addr_o,
    output logic [31:0]      mem_din_o,
    input  logic [31:0]      mem_dout_i
);

    typedef enum logic {
        S_UNLOCKED,
        S_LOCKED
    } state_t;

    localparam logic [8:0] CNT_MAX = 9'(MAX_LOCK);

    state_t     state;
    logic       last_owner;
    logic [7:0] lock_cnt;
    logic       resp_pending;
    logic       resp_owner;
    logic       resp_we;

    logic       hold;
    logic       tie;
    logic       win_v;
    logic       win;
    logic [8:0] cnt_nxt;

    // The lock owner is always the master granted last.
    assign hold    = (state == S_LOCKED) && req_i[last_owner];
    assign cnt_nxt = {1'b0, lock_cnt} + 9'd1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie = 1'b0;
`else
    assign tie = ~last_owner;
`endif

    always_comb begin
        win_v = 1'b0;
        win   = 1'b0;
        priority case (1'b1)
            !rstn: ;
            hold: begin
                win_v = 1'b1;
                win   = last_owner;
            end
            &req_i: begin
                win_v = 1'b1;
                win   = tie;
            end
            req_i[0]: begin
                win_v = 1'b1;
                win   = 1'b0;
            end
            req_i[1]: begin
                win_v = 1'b1;
                win   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt_o      = 2'b00;
        mem_en_o   = 4'h0;
        mem_we_o   = 1'b0;
        mem_addr_o = 14'h0;
        mem_din_o  = 32'h0;
        if (win_v) begin
            gnt_o[win] = 1'b1;
            mem_en_o   = be_i[win];
            mem_we_o   = we_i[win];
            mem_addr_o = addr_i[win];
            mem_din_o  = wdata_i[win];
        end
    end

    assign rvalid_o = {resp_pending & resp_owner, resp_pending & ~resp_owner};

    always_comb begin
        rdata_o = '0;
        if (resp_pending && !resp_we) begin
            rdata_o[resp_owner] = mem_dout_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_UNLOCKED;
            last_owner   <= 1'b1;
            lock_cnt     <= 8'd0;
            resp_pending <= 1'b0;
            resp_owner   <= 1'b0;
            resp_we      <= 1'b0;
        end else begin
            resp_pending <= win_v;
            resp_owner   <= win;
            resp_we      <= win_v & we_i[win];
            if (!win_v) begin
                state <= S_UNLOCKED;
            end else begin
                last_owner <= win;
                if (hold) begin
                    lock_cnt <= cnt_nxt[7:0];
                    if (!lock_i[win] || cnt_nxt >= CNT_MAX) begin
                        state <= S_UNLOCKED;
                    end
                end else if (lock_i[win] && MAX_LOCK > 1) begin
                    state    <= S_LOCKED;
                    lock_cnt <= 8'd1;
                end else begin
                    state <= S_UNLOCKED;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a byte-masking memory model.
// Built with MAX_LOCK=4 so the lock bound is reachable quickly.
module tb_mem_port_arb;

    logic             clk;
    logic             rstn;
    logic [1:0]       req;
    logic [1:0]       lock;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][13:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
    logic [3:0]       mem_en;
    logic             mem_we;
    logic [13:0]      mem_addr;
    logic [31:0]      mem_din;
    logic [31:0]      mem_dout;

    int checks = 0;
    int errors = 0;

    mem_port_arb #(.MAX_LOCK(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_i      (req),
        .lock_i     (lock),
        .we_i       (we),
        .be_i       (be),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .mem_dout_i (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: masks read data per byte enable, holds dout when not reading.
    logic [31:0] mem [0:16383];
    logic        ld;
    logic [13:0] ld_a;
    logic [31:0] ld_d;

    always @(posedge clk) begin
        if (ld) begin
            mem[ld_a] <= ld_d;
        end else if (mem_en != 4'h0 && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_en[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
        if (mem_en != 4'h0 && !mem_we) begin
            for (int b = 0; b < 4; b++)
                mem_dout[8*b +: 8] <= mem_en[b] ? mem[mem_addr][8*b +: 8] : 8'h00;
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [1:0]  we;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [13:0] a0;
        logic [13:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  x_gnt;
        logic [3:0]  x_en;
        logic        x_we;
        logic [13:0] x_addr;
        logic [31:0] x_din;
        logic [1:0]  x_rv;
        logic [31:0] x_rd0;
        logic [31:0] x_rd1;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [3:0] b0, input logic [3:0] b1,
                         input logic [13:0] a0, input logic [13:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req      = r;
        lock     = l;
        we       = w;
        be[0]    = b0;
        be[1]    = b1;
        addr[0]  = a0;
        addr[1]  = a1;
        wdata[0] = d0;
        wdata[1] = d1;
    endtask

    localparam logic [31:0] C0 = 32'hC0C0_0000;
    localparam logic [31:0] C1 = 32'hC1C1_0000;

    logic [1:0] lg [5];
    logic [1:0] prev;

    initial begin
        vt[0]  = '{2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b01, 4'hF, 1'b0, 14'h10, C0, 2'b00, 32'h0, 32'h0};
        vt[1]  = '{2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b10, 4'hF, 1'b0, 14'h11, C1, 2'b01, 32'hDEADBEEF, 32'h0};
        vt[2]  = '{2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b01, 4'hF, 1'b0, 14'h10, C0, 2'b10, 32'h0, 32'h01020304};
        vt[3]  = '{2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b10, 4'hF, 1'b0, 14'h11, C1, 2'b01, 32'hDEADBEEF, 32'h0};
        vt[4]  = '{2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b01, 4'hF, 1'b0, 14'h10, C0, 2'b10, 32'h0, 32'h01020304};
        vt[5]  = '{2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b10, 4'hF, 1'b0, 14'h11, C1, 2'b01, 32'hDEADBEEF, 32'h0};
        vt[6]  = '{2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, C0, C1,
                   2'b00, 4'h0, 1'b0, 14'h0, 32'h0, 2'b10, 32'h0, 32'h01020304};
        vt[7]  = '{2'b01, 2'b00, 2'b00, 4'hF, 4'h0, 14'h10, 14'h0, 32'h0, 32'h0,
                   2'b01, 4'hF, 1'b0, 14'h10, 32'h0, 2'b00, 32'h0, 32'h0};
        vt[8]  = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 14'h0, 14'h0, 32'h0, 32'h0,
                   2'b00, 4'h0, 1'b0, 14'h0, 32'h0, 2'b01, 32'hDEADBEEF, 32'h0};
        vt[9]  = '{2'b10, 2'b00, 2'b10, 4'h0, 4'h3, 14'h0, 14'h100, 32'h0, 32'h11223344,
                   2'b10, 4'h3, 1'b1, 14'h100, 32'h11223344, 2'b00, 32'h0, 32'h0};
        vt[10] = '{2'b10, 2'b00, 2'b00, 4'h0, 4'hF, 14'h0, 14'h100, 32'h0, 32'h0,
                   2'b10, 4'hF, 1'b0, 14'h100, 32'h0, 2'b10, 32'h0, 32'h0};
        vt[11] = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 14'h0, 14'h0, 32'h0, 32'h0,
                   2'b00, 4'h0, 1'b0, 14'h0, 32'h0, 2'b10, 32'h0, 32'hAABB3344};
        vt[12] = '{2'b10, 2'b00, 2'b00, 4'h0, 4'h3, 14'h0, 14'h100, 32'h0, 32'h0,
                   2'b10, 4'h3, 1'b0, 14'h100, 32'h0, 2'b00, 32'h0, 32'h0};
        vt[13] = '{2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 14'h0, 14'h0, 32'h0, 32'h0,
                   2'b00, 4'h0, 1'b0, 14'h0, 32'h0, 2'b10, 32'h0, 32'h00003344};

        rstn = 1'b0;
        ld   = 1'b0;
        ld_a = 14'h0;
        ld_d = 32'h0;
        drive(2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, 32'h0, 32'h0);

        // Reset state, with both masters requesting.
        repeat (2) @(negedge clk);
        #1;
        chk("rst gnt", 32'(gnt), 32'h0);
        chk("rst rvalid", 32'(rvalid), 32'h0);
        chk("rst rdata0", rdata[0], 32'h0);
        chk("rst rdata1", rdata[1], 32'h0);
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);

        @(negedge clk);
        ld = 1'b1; ld_a = 14'h10;  ld_d = 32'hDEADBEEF;
        @(negedge clk);
        ld_a = 14'h11;  ld_d = 32'h01020304;
        @(negedge clk);
        ld_a = 14'h100; ld_d = 32'hAABBCCDD;
        @(negedge clk);
        ld = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 14'h0, 14'h0, 32'h0, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vt[i].req, vt[i].lock, vt[i].we, vt[i].be0, vt[i].be1,
                  vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
            #1;
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vt[i].x_gnt));
            chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vt[i].x_en));
            chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vt[i].x_we));
            chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].x_addr));
            chk($sformatf("row%0d mem_din", i), mem_din, vt[i].x_din);
            chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(vt[i].x_rv));
            chk($sformatf("row%0d rdata0", i), rdata[0], vt[i].x_rd0);
            chk($sformatf("row%0d rdata1", i), rdata[1], vt[i].x_rd1);
        end

        // Lock bound: master 0 keeps lock asserted against master 1.
        lg[0] = 2'b01; lg[1] = 2'b01; lg[2] = 2'b01; lg[3] = 2'b01; lg[4] = 2'b10;
        prev = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(2'b11, 2'b01, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, 32'h0, 32'h0);
            #1;
            chk($sformatf("lock%0d gnt", i), 32'(gnt), 32'(lg[i]));
            chk($sformatf("lock%0d rvalid", i), 32'(rvalid), 32'(prev));
            prev = lg[i];
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 14'h0, 14'h0, 32'h0, 32'h0);
        #1;
        chk("lockend rvalid", 32'(rvalid), 32'h2);
        chk("lockend rdata1", rdata[1], 32'h01020304);

        // Lock drop: locked master 0 releases req, master 1 granted at once.
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b00, 4'hF, 4'h0, 14'h10, 14'h0, 32'h0, 32'h0);
        #1;
        chk("drop lockgnt", 32'(gnt), 32'h1);
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 4'h0, 4'hF, 14'h0, 14'h11, 32'h0, 32'h0);
        #1;
        chk("drop gnt", 32'(gnt), 32'h2);
        chk("drop mem_addr", 32'(mem_addr), 32'h11);

        // Reset during a read: response dropped, tie priority restored.
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 4'hF, 4'h0, 14'h10, 14'h0, 32'h0, 32'h0);
        #1;
        chk("mid pre gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        #1;
        chk("mid gnt", 32'(gnt), 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid rst gnt", 32'(gnt), 32'h0);
        chk("mid rst rvalid", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        chk("mid post rvalid", 32'(rvalid), 32'h0);
        chk("mid post rdata0", rdata[0], 32'h0);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 4'hF, 4'hF, 14'h10, 14'h11, 32'h0, 32'h0);
        rstn = 1'b1;
        #1;
        chk("after rst gnt", 32'(gnt), 32'h1);
        chk("after rst rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 14'h0, 14'h0, 32'h0, 32'h0);
        #1;
        chk("after rst rdata0", rdata[0], 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
